// File: rtl/demux_class_n.sv
// demux_class_n: 1-to-N class demultiplexer with a show-ahead FIFO per lane.
// The class field of each input word picks the lane; lanes drain independently.
module demux_class_n #(
    parameter int DATA_W    = 10,
    parameter int CLASS_LSB = 8,
    parameter int CLASS_W   = 1,
    parameter int DEPTH     = 4,
    parameter int AF_LEVEL  = 3,
    parameter int HOLD_LAST = 1,
    localparam int N_OUT    = 2 ** CLASS_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      valid_in,
    output logic                      ready_in,
    output logic [N_OUT*DATA_W-1:0]   data_out,
    output logic [N_OUT-1:0]          valid_out,
    input  logic [N_OUT-1:0]          pop,
    output logic [N_OUT-1:0]          almost_full,
    output logic [N_OUT-1:0]          full,
    output logic [N_OUT-1:0]          pop_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CLASS_W-1:0] sel;

    assign sel      = data_in[CLASS_LSB +: CLASS_W];
    // Acceptance depends only on registered occupancy, never on pop.
    assign ready_in = !full[sel];

    for (genvar i = 0; i < N_OUT; i++) begin : g_lane
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  cnt;
        logic              perr;
        logic              push;
        logic              pop_ok;
        logic [DATA_W-1:0] head;

        assign push   = valid_in && !full[i] && (sel == CLASS_W'(i));
        assign pop_ok = pop[i] && valid_out[i];
        assign head   = mem[rd_ptr];

        assign valid_out[i]   = (cnt != '0);
        assign full[i]        = (cnt == CNT_W'(DEPTH));
        assign almost_full[i] = (cnt >= CNT_W'(AF_LEVEL));
        assign pop_err[i]     = perr;

        // Storage array; stale contents are harmless once pointers reset.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= data_in;
            end
        end

        // Pointers, occupancy and the sticky empty-pop flag.
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                perr   <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (pop[i] && !valid_out[i]) begin
                    perr <= 1'b1;
                end
                if (push && !pop_ok) begin
                    cnt <= cnt + 1'b1;
                end else if (!push && pop_ok) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end

        if (HOLD_LAST != 0) begin : g_hold
            logic [DATA_W-1:0] last;

            // Capture each popped word so an idle lane keeps showing it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    last <= '0;
                end else if (pop_ok) begin
                    last <= head;
                end
            end

            assign data_out[i*DATA_W +: DATA_W] = valid_out[i] ? head : last;
        end else begin : g_zero
            assign data_out[i*DATA_W +: DATA_W] = valid_out[i] ? head : '0;
        end
    end

endmodule

// File: tb/tb_demux_class_n.sv
// tb_demux_class_n: directed and random checks of demux_class_n against
// a queue-based lane model, for both idle-lane display modes.
module tb_demux_class_n;

    localparam int DW    = 10;
    localparam int NO    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic [NO-1:0] pop;

    logic              rdy_h, rdy_z;
    logic [NO*DW-1:0]  dout_h, dout_z;
    logic [NO-1:0]     vo_h, vo_z, af_h, af_z, fu_h, fu_z, pe_h, pe_z;

    int vectors = 0;
    int errs    = 0;
    bit chk_en  = 1'b0;

    logic [DW-1:0] q [NO][$];
    logic [DW-1:0] mlast [NO];
    logic [NO-1:0] mperr;

    always #5 clk = ~clk;

    demux_class_n #(.HOLD_LAST(1)) dut_h (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rdy_h), .data_out(dout_h), .valid_out(vo_h), .pop(pop),
        .almost_full(af_h), .full(fu_h), .pop_err(pe_h)
    );

    demux_class_n #(.HOLD_LAST(0)) dut_z (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rdy_z), .data_out(dout_z), .valid_out(vo_z), .pop(pop),
        .almost_full(af_z), .full(fu_z), .pop_err(pe_z)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Drive one cycle, clock it, then advance the model past that edge.
    task automatic step(input logic vin, input logic [DW-1:0] din,
                        input logic [NO-1:0] p, input logic rst);
        int s;
        bit r;
        reset    = rst;
        valid_in = vin;
        data_in  = din;
        pop      = p;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NO; i++) begin
                q[i].delete();
                mlast[i] = '0;
            end
            mperr = '0;
        end else begin
            s = int'(din[8]);
            r = (q[s].size() < DEPTH);
            for (int i = 0; i < NO; i++) begin
                if (p[i]) begin
                    if (q[i].size() > 0) mlast[i] = q[i].pop_front();
                    else mperr[i] = 1'b1;
                end
            end
            if (vin && r) q[s].push_back(din);
        end
        chk_en = 1'b1;
        #1;
    endtask

    task automatic peek_ready(input logic [DW-1:0] din, input logic exp);
        valid_in = 1'b1;
        data_in  = din;
        pop      = '0;
        #1;
        chk("ready_peek_h", 64'(rdy_h), 64'(exp));
        chk("ready_peek_z", 64'(rdy_z), 64'(exp));
    endtask

    // Compare both DUTs with the model every cycle, mid-period.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NO-1:0]    ev, ef, eaf;
            logic [NO*DW-1:0] eh, ez;
            logic             er;
            for (int i = 0; i < NO; i++) begin
                ev[i]  = q[i].size() != 0;
                ef[i]  = q[i].size() == DEPTH;
                eaf[i] = q[i].size() >= AF;
                eh[i*DW +: DW] = ev[i] ? q[i][0] : mlast[i];
                ez[i*DW +: DW] = ev[i] ? q[i][0] : '0;
            end
            er = q[int'(data_in[8])].size() < DEPTH;
            chk("valid_out_h", 64'(vo_h), 64'(ev));
            chk("valid_out_z", 64'(vo_z), 64'(ev));
            chk("full_h", 64'(fu_h), 64'(ef));
            chk("full_z", 64'(fu_z), 64'(ef));
            chk("almost_full_h", 64'(af_h), 64'(eaf));
            chk("almost_full_z", 64'(af_z), 64'(eaf));
            chk("data_out_h", 64'(dout_h), 64'(eh));
            chk("data_out_z", 64'(dout_z), 64'(ez));
            chk("pop_err_h", 64'(pe_h), 64'(mperr));
            chk("pop_err_z", 64'(pe_z), 64'(mperr));
            chk("ready_in_h", 64'(rdy_h), 64'(er));
            chk("ready_in_z", 64'(rdy_z), 64'(er));
        end
    end

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        pop      = '0;
        mperr    = '0;
        for (int i = 0; i < NO; i++) mlast[i] = '0;
        @(negedge clk);

        step(0, 0, 2'b00, 1);
        chk("rst_valid", 64'(vo_h), 64'h0);
        chk("rst_data", 64'(dout_h), 64'h0);
        chk("rst_full", 64'(fu_h | af_h), 64'h0);
        peek_ready(10'h0AA, 1'b1);
        peek_ready(10'h1AA, 1'b1);

        step(1, 10'h001, 2'b00, 0);
        chk("first_head", 64'(dout_h[9:0]), 64'h001);
        step(1, 10'h002, 2'b00, 0);
        step(1, 10'h101, 2'b00, 0);
        step(1, 10'h102, 2'b00, 0);
        chk("two_lane_valid", 64'(vo_h), 64'h3);
        chk("two_lane_data", 64'(dout_h), 64'({10'h101, 10'h001}));
        chk("model_occ0", 64'(q[0].size()), 64'd2);

        step(0, 0, 2'b00, 1);
        step(1, 10'h011, 2'b00, 0);
        step(1, 10'h012, 2'b00, 0);
        step(1, 10'h013, 2'b00, 0);
        chk("af_after_3", 64'({af_h, fu_h}), 64'({2'b01, 2'b00}));
        step(1, 10'h014, 2'b00, 0);
        chk("full_after_4", 64'(fu_h), 64'h1);
        peek_ready(10'h015, 1'b0);
        peek_ready(10'h115, 1'b1);
        step(1, 10'h015, 2'b01, 0);
        chk("refused_head", 64'(dout_h[9:0]), 64'h012);
        chk("refused_full", 64'(fu_h), 64'h0);
        step(1, 10'h015, 2'b00, 0);
        chk("accepted_full", 64'(fu_h), 64'h1);

        step(0, 0, 2'b00, 1);
        step(1, 10'h055, 2'b00, 0);
        step(0, 0, 2'b01, 0);
        chk("hold_valid", 64'(vo_h[0]), 64'h0);
        chk("hold_last", 64'(dout_h[9:0]), 64'h055);
        chk("hold_zero", 64'(dout_z[9:0]), 64'h000);

        step(0, 0, 2'b10, 0);
        chk("pop_err_set", 64'(pe_h), 64'h2);
        for (int k = 0; k < 10; k++) step(0, 0, 2'b00, 0);
        chk("pop_err_sticky", 64'(pe_h), 64'h2);

        step(0, 0, 2'b00, 1);
        step(1, 10'h0A0, 2'b00, 0);
        for (int k = 0; k < 12; k++) begin
            step(1, 10'h0A1 + 10'(k), 2'b01, 0);
            chk("wrap_head", 64'(dout_h[9:0]), 64'(10'h0A1 + 10'(k)));
        end
        step(0, 0, 2'b01, 0);
        chk("wrap_last", 64'(dout_h[9:0]), 64'h0AC);

        step(0, 0, 2'b00, 1);
        step(1, 10'h021, 2'b00, 0);
        step(1, 10'h022, 2'b00, 0);
        step(1, 10'h023, 2'b00, 0);
        step(1, 10'h121, 2'b00, 0);
        step(1, 10'h122, 2'b00, 0);
        step(1, 10'h024, 2'b11, 1);
        chk("midrst_zero", 64'({vo_h, fu_h, pe_h, dout_h}), 64'h0);
        step(1, 10'h077, 2'b00, 0);
        chk("post_rst_push", 64'({vo_h, dout_h[9:0]}), 64'({2'b01, 10'h077}));

        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 3) != 0), DW'($urandom),
                 NO'($urandom_range(0, 3) == 0 ? $urandom : 0),
                 ($urandom_range(0, 199) == 0));
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/demux_class_n.md
Name: demux_class_n

Overview:
- Parametrised 1-to-N class demultiplexer, successor to the 2-way class demux in the classification stage.
- Routes each input word to one of N_OUT output lanes, selected by the class field inside the word.
- Each lane buffers words in its own FIFO, so a stalled consumer does not block the other lanes.
- Lanes present a show-ahead valid/pop interface. An idle lane holds either its last word or zero, selected by parameter.

Parameters:
- DATA_W, 10: word width in bits.
- CLASS_LSB, 8: bit index of the class field LSB within the word.
- CLASS_W, 1: class field width; N_OUT = 2**CLASS_W lanes. CLASS_LSB+CLASS_W <= DATA_W.
- DEPTH, 4: entries per lane FIFO; power of 2, >= 2.
- AF_LEVEL, 3: occupancy at or above which almost_full[i] asserts; 1 <= AF_LEVEL <= DEPTH.
- HOLD_LAST, 1: 1 = an empty lane shows its last popped word; 0 = an empty lane shows all-zero.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  input word; its class field is data_in[CLASS_LSB +: CLASS_W].
- valid_in  in  1  data_in is valid this cycle.
- ready_in  out  1  the target lane of the current data_in can accept it (combinational).
- data_out  out  N_OUT*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- valid_out  out  N_OUT  lane i FIFO is non-empty.
- pop  in  N_OUT  consumer of lane i takes the head word this cycle.
- almost_full  out  N_OUT  lane i occupancy >= AF_LEVEL.
- full  out  N_OUT  lane i occupancy == DEPTH.
- pop_err  out  N_OUT  sticky flag: lane i was popped while empty.

Behaviour:
- Reset is synchronous. On a clk edge with reset=1:
  - all FIFO pointers and occupancy counts go to 0;
  - the last-word registers go to 0;
  - pop_err goes to 0.
  - From the next cycle: valid_out=0, full=0, almost_full=0, data_out=0. ready_in=1 for any class.
- Reset asserted mid-operation discards all buffered words. valid_in and pop are ignored in that cycle.
- Lane select: sel = data_in[CLASS_LSB +: CLASS_W].
- ready_in = !full[sel]. It is purely combinational from data_in and the FIFO state, with no dependence on pop.
- Push: occurs when valid_in && ready_in. The word is written to lane sel. Its occupancy rises by 1 and the word is visible on the lane one cycle after the accepting edge (latency 1).
- Push refused: when valid_in && !ready_in, the word is not stored. The source must hold data_in and valid_in until accepted; this block adds no drop counter.
- Full lane with simultaneous pop: there is no bypass. ready_in stays 0 that cycle and the push is refused. The slot freed by the pop is usable from the next cycle.
- Lane output, show-ahead:
  - if valid_out[i]=1, the lane i slice of data_out is the FIFO head;
  - else it is last[i] when HOLD_LAST=1, and 0 when HOLD_LAST=0.
- Pop: occurs when pop[i] && valid_out[i]. The head advances at the edge. last[i] loads the popped word. Occupancy falls by 1.
- Simultaneous push and pop on the same non-full lane: occupancy is unchanged and both pointers advance.
- Push and pop on different lanes in the same cycle are independent.
- Pop on an empty lane: ignored, with no pointer or occupancy change. pop_err[i] sets the next cycle and stays set until reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH, so DEPTH entries are usable.
- full, almost_full and valid_out are decoded from registered occupancy and are glitch-free.
- No combinational path exists from pop to ready_in, valid_out or data_out.

Test Plan:
- Reset, then stream class-0 words 0x001, 0x002 and class-1 words 0x101, 0x102 with pop=0 -> lane0 head 0x001 and lane1 head 0x101, each one cycle after acceptance. valid_out=2'b11. Occupancy is 2 per lane.
- Fill lane0 with DEPTH=4 words 0x011..0x014 -> almost_full[0] asserts after the 3rd push and full[0] after the 4th. A 5th class-0 word sees ready_in=0 while a class-1 word that cycle sees ready_in=1. Then pop[0]=1 with a class-0 word pending -> push refused that cycle, accepted the cycle after.
- With HOLD_LAST=1, push 0x055 and pop it -> valid_out[0]=0 and lane0 data_out stays 0x055. With HOLD_LAST=0 -> lane0 data_out=0x000.
- Pop lane1 while empty -> lane state unchanged, pop_err[1]=1 next cycle and still 1 ten cycles later. pop_err[0] stays 0.
- Run 12 push/pop pairs on one lane to wrap the pointers three times -> output order equals input order and occupancy stays at 1.
- Assert reset with lanes holding 3 and 2 words -> next cycle valid_out=0, full=0, data_out=0, pop_err=0. A new word is accepted on the following cycle.
